alu_resp_checker: RTL and testbench



---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_ref_model.sv | 28 ++
 rtl/alu_resp_checker.sv | 164 ++++++++++++++++
 tb/tb_alu_resp_checker.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the four-bit ALU blocks: opcodes, checker states, default width.
package alu_pkg;

   localparam int unsigned ALU_WIDTH = 4;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_XOR = 3'b010;
   localparam logic [2:0] OP_NOT = 3'b011;
   localparam logic [2:0] OP_ADD = 3'b100;
   localparam logic [2:0] OP_SUB = 3'b101;
   localparam logic [2:0] OP_SHL = 3'b110;
   localparam logic [2:0] OP_SHR = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } chk_state_e;

endpackage

// File: rtl/alu_ref_model.sv
// Combinational reference ALU: expected result for (op, a, b).
module alu_ref_model
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = ALU_WIDTH
) (
   input  logic [2:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] y_o
);

   always_comb begin
      y_o = '0;
      case (op_i)
         OP_AND:  y_o = a_i & b_i;
         OP_OR:   y_o = a_i | b_i;
         OP_XOR:  y_o = a_i ^ b_i;
         OP_NOT:  y_o = ~a_i;
         OP_ADD:  y_o = a_i + b_i;
         OP_SUB:  y_o = a_i - b_i;
         OP_SHL:  y_o = {a_i[WIDTH-2:0], 1'b0};
         OP_SHR:  y_o = {1'b0, a_i[WIDTH-1:1]};
         default: y_o = '0;
      endcase
   end

endmodule

// File: rtl/alu_resp_checker.sv
// ALU response checker: accepts beats, compares against alu_ref_model through a
// 2-stage pipe and keeps saturating pass/fail counts plus the first failing index.
module alu_resp_checker
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = ALU_WIDTH,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             finish,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [WIDTH-1:0] in_y,
   output logic             busy,
   output logic             done,
   output logic             all_pass,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] fail_cnt,
   output logic             first_fail_vld,
   output logic [CNT_W-1:0] first_fail_idx
);

   chk_state_e state_q, state_d;
   logic       clear;
   logic       accept;

   logic             s1_vld_q, s1_vld_d;
   logic [2:0]       s1_op_q, s1_op_d;
   logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d, s1_y_q, s1_y_d;
   logic [CNT_W-1:0] s1_idx_q, s1_idx_d;
   logic             s2_vld_q, s2_vld_d;
   logic             s2_pass_q, s2_pass_d;
   logic [CNT_W-1:0] s2_idx_q, s2_idx_d;

   logic [CNT_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0] pass_q, pass_d, fail_q, fail_d, ff_idx_q, ff_idx_d;
   logic             ff_vld_q, ff_vld_d;
   logic [WIDTH-1:0] ref_y;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

   alu_ref_model #(.WIDTH(WIDTH)) u_ref (
      .op_i (s1_op_q),
      .a_i  (s1_a_q),
      .b_i  (s1_b_q),
      .y_o  (ref_y)
   );

   assign in_ready = (state_q == ST_RUN);
   assign accept   = in_valid && in_ready;

   always_comb begin
      state_d = state_q;
      clear   = 1'b0;
      case (state_q)
         ST_IDLE: if (start) begin
            state_d = ST_RUN;
            clear   = 1'b1;
         end
         ST_RUN:   if (finish) state_d = ST_DRAIN;
         // Stage 2 retires into the counters on the same edge that enters DONE.
         ST_DRAIN: if (!s1_vld_q) state_d = ST_DONE;
         ST_DONE: if (start) begin
            state_d = ST_RUN;
            clear   = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      s1_vld_d  = accept;
      s1_op_d   = s1_op_q;
      s1_a_d    = s1_a_q;
      s1_b_d    = s1_b_q;
      s1_y_d    = s1_y_q;
      s1_idx_d  = s1_idx_q;
      s2_vld_d  = s1_vld_q;
      s2_pass_d = (ref_y == s1_y_q);
      s2_idx_d  = s1_idx_q;
      idx_d     = idx_q;
      pass_d    = pass_q;
      fail_d    = fail_q;
      ff_vld_d  = ff_vld_q;
      ff_idx_d  = ff_idx_q;
      if (accept) begin
         s1_op_d  = in_op;
         s1_a_d   = in_a;
         s1_b_d   = in_b;
         s1_y_d   = in_y;
         s1_idx_d = idx_q;
         idx_d    = sat_inc(idx_q);
      end
      if (clear) begin
         idx_d    = '0;
         pass_d   = '0;
         fail_d   = '0;
         ff_vld_d = 1'b0;
         ff_idx_d = '0;
      end else if (s2_vld_q) begin
         if (s2_pass_q) begin
            pass_d = sat_inc(pass_q);
         end else begin
            fail_d = sat_inc(fail_q);
            if (!ff_vld_q) begin
               ff_vld_d = 1'b1;
               ff_idx_d = s2_idx_q;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         s1_vld_q  <= 1'b0;
         s1_op_q   <= '0;
         s1_a_q    <= '0;
         s1_b_q    <= '0;
         s1_y_q    <= '0;
         s1_idx_q  <= '0;
         s2_vld_q  <= 1'b0;
         s2_pass_q <= 1'b0;
         s2_idx_q  <= '0;
         idx_q     <= '0;
         pass_q    <= '0;
         fail_q    <= '0;
         ff_vld_q  <= 1'b0;
         ff_idx_q  <= '0;
      end else begin
         state_q   <= state_d;
         s1_vld_q  <= s1_vld_d;
         s1_op_q   <= s1_op_d;
         s1_a_q    <= s1_a_d;
         s1_b_q    <= s1_b_d;
         s1_y_q    <= s1_y_d;
         s1_idx_q  <= s1_idx_d;
         s2_vld_q  <= s2_vld_d;
         s2_pass_q <= s2_pass_d;
         s2_idx_q  <= s2_idx_d;
         idx_q     <= idx_d;
         pass_q    <= pass_d;
         fail_q    <= fail_d;
         ff_vld_q  <= ff_vld_d;
         ff_idx_q  <= ff_idx_d;
      end
   end

   assign busy           = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign done           = (state_q == ST_DONE);
   assign all_pass       = done && (fail_q == '0) && (pass_q != '0);
   assign pass_cnt       = pass_q;
   assign fail_cnt       = fail_q;
   assign first_fail_vld = ff_vld_q;
   assign first_fail_idx = ff_idx_q;

endmodule

// File: tb/tb_alu_resp_checker.sv
// Directed bench for alu_resp_checker with hand-computed expected counts.
module tb_alu_resp_checker;
   import alu_pkg::*;

   localparam int unsigned W  = 4;
   localparam int unsigned CW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0, finish = 1'b0, in_valid = 1'b0;
   logic          in_ready;
   logic [2:0]    in_op = '0;
   logic [W-1:0]  in_a = '0, in_b = '0, in_y = '0;
   logic          busy, done, all_pass, first_fail_vld;
   logic [CW-1:0] pass_cnt, fail_cnt, first_fail_idx;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc;

   alu_resp_checker #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .finish         (finish),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_op          (in_op),
      .in_a           (in_a),
      .in_b           (in_b),
      .in_y           (in_y),
      .busy           (busy),
      .done           (done),
      .all_pass       (all_pass),
      .pass_cnt       (pass_cnt),
      .fail_cnt       (fail_cnt),
      .first_fail_vld (first_fail_vld),
      .first_fail_idx (first_fail_idx)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic beat(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] y, input logic fin);
      in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_y = y; finish = fin;
      @(posedge clk); #1;
      in_valid = 1'b0; finish = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic pulse_finish();
      finish = 1'b1;
      @(posedge clk); #1;
      finish = 1'b0;
   endtask

   // Called #1 after the finish edge; cnt = edges from the finish edge to done.
   task automatic wait_done(output int cnt);
      cnt = 1;
      while (!done && cnt < 8) begin
         @(posedge clk); #1;
         cnt++;
      end
      if (!done) chk("done_timeout", 32'(done), 32'(1));
   endtask

   initial begin
      #12;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_ready", 32'(in_ready), 0);
      chk("rst_pass", 32'(pass_cnt), 0);
      chk("rst_fail", 32'(fail_cnt), 0);
      chk("rst_ffv", 32'(first_fail_vld), 0);
      chk("rst_allp", 32'(all_pass), 0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;

      // In IDLE in_valid has no effect.
      beat(OP_AND, 4'b1111, 4'b1111, 4'b1111, 1'b0);
      chk("idle_busy", 32'(busy), 0);

      // AND vectors
      pulse_start();
      chk("run_busy", 32'(busy), 1);
      chk("run_ready", 32'(in_ready), 1);
      beat(OP_AND, 4'b1010, 4'b0110, 4'b0010, 1'b0);
      beat(OP_AND, 4'b1111, 4'b0000, 4'b0000, 1'b0);
      beat(OP_AND, 4'b1010, 4'b1010, 4'b1010, 1'b0);
      pulse_finish();
      wait_done(cyc);
      chk("and_done_lat_ok", 32'(cyc <= 3), 1);
      chk("and_pass", 32'(pass_cnt), 3);
      chk("and_fail", 32'(fail_cnt), 0);
      chk("and_allp", 32'(all_pass), 1);
      chk("and_ffv", 32'(first_fail_vld), 0);
      chk("and_busy", 32'(busy), 0);
      pulse_finish();
      chk("done_hold", 32'(done), 1);

      // Wrap-around arithmetic plus the remaining opcodes
      pulse_start();
      chk("restart_pass", 32'(pass_cnt), 0);
      beat(OP_ADD, 4'b1111, 4'b0001, 4'b0000, 1'b0);
      beat(OP_SUB, 4'b0000, 4'b0001, 4'b1111, 1'b0);
      beat(OP_OR,  4'b1000, 4'b0001, 4'b1001, 1'b0);
      beat(OP_XOR, 4'b1100, 4'b1010, 4'b0110, 1'b0);
      beat(OP_NOT, 4'b1010, 4'b1111, 4'b0101, 1'b0);
      beat(OP_SHL, 4'b1011, 4'b0000, 4'b0110, 1'b0);
      beat(OP_SHR, 4'b1011, 4'b0000, 4'b0101, 1'b0);
      pulse_finish();
      wait_done(cyc);
      chk("ops_pass", 32'(pass_cnt), 7);
      chk("ops_fail", 32'(fail_cnt), 0);

      // One failure at beat 2, latency probe, start ignored in RUN
      pulse_start();
      beat(OP_AND, 4'b1010, 4'b0110, 4'b0010, 1'b0);
      chk("lat_e1", 32'(pass_cnt), 0);
      beat(OP_XOR, 4'b1100, 4'b1010, 4'b0110, 1'b0);
      chk("lat_e2_pre", 32'(pass_cnt), 0);
      beat(OP_OR,  4'b1000, 4'b0001, 4'b0000, 1'b0);
      chk("lat_e2_post", 32'(pass_cnt), 1);
      pulse_start();
      beat(OP_ADD, 4'b0011, 4'b0100, 4'b0111, 1'b0);
      beat(OP_SHL, 4'b0001, 4'b0000, 4'b0010, 1'b0);
      pulse_finish();
      wait_done(cyc);
      chk("ff_pass", 32'(pass_cnt), 4);
      chk("ff_fail", 32'(fail_cnt), 1);
      chk("ff_vld", 32'(first_fail_vld), 1);
      chk("ff_idx", 32'(first_fail_idx), 2);
      chk("ff_allp", 32'(all_pass), 0);

      // finish with an accepted beat, in_valid held through DRAIN/DONE
      pulse_start();
      in_valid = 1'b1; in_op = OP_AND; in_a = 4'b1111; in_b = 4'b1111; in_y = 4'b1111;
      finish = 1'b1;
      @(posedge clk); #1;
      finish = 1'b0; in_y = 4'b0000;
      chk("drain_ready", 32'(in_ready), 0);
      wait_done(cyc);
      chk("fin_done_lat_ok", 32'(cyc <= 3), 1);
      chk("fin_pass", 32'(pass_cnt), 1);
      chk("fin_fail", 32'(fail_cnt), 0);
      chk("done_ready", 32'(in_ready), 0);
      @(posedge clk); #1;
      chk("done_valid_ignored", 32'(fail_cnt), 0);
      in_valid = 1'b0;

      // Reset mid-run with two beats in the pipe
      pulse_start();
      beat(OP_AND, 4'b1111, 4'b1111, 4'b1111, 1'b0);
      beat(OP_AND, 4'b1111, 4'b1111, 4'b1111, 1'b0);
      beat(OP_AND, 4'b1111, 4'b1111, 4'b1111, 1'b0);
      chk("pre_rst_pass", 32'(pass_cnt), 1);
      rst = 1'b1; #1;
      chk("mrst_busy", 32'(busy), 0);
      chk("mrst_ready", 32'(in_ready), 0);
      chk("mrst_pass", 32'(pass_cnt), 0);
      chk("mrst_done", 32'(done), 0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_idle_done", 32'(done), 0);
      start = 1'b1; finish = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; finish = 1'b0;
      chk("sf_busy", 32'(busy), 1);
      chk("sf_ready", 32'(in_ready), 1);
      beat(OP_SUB, 4'b0101, 4'b0011, 4'b0010, 1'b0);
      pulse_finish();
      wait_done(cyc);
      chk("rst_run_pass", 32'(pass_cnt), 1);
      chk("rst_run_fail", 32'(fail_cnt), 0);

      // Saturation: 300 passing beats, then a failing beat at index 300
      pulse_start();
      for (int i = 0; i < 300; i++) beat(OP_AND, 4'b1111, 4'b1111, 4'b1111, 1'b0);
      beat(OP_AND, 4'b1111, 4'b1111, 4'b0000, 1'b1);
      wait_done(cyc);
      chk("sat_pass", 32'(pass_cnt), 255);
      chk("sat_fail", 32'(fail_cnt), 1);
      chk("sat_ffidx", 32'(first_fail_idx), 255);
      chk("sat_allp", 32'(all_pass), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
